// File: rtl/led_blinker.sv
// Drives one active-low LED pad with a commanded number of fixed-length blinks.
// A start/busy/done handshake sequences each command; abort cancels at once.
module led_blinker #(
    parameter int ON_TICKS  = 128,
    parameter int OFF_TICKS = 128,
    parameter int TIMER_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] blink_count,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       led_out,
    output logic [1:0] fsm_state
);

    // Handshake: start is taken only in IDLE with abort low; busy stays high from the
    // edge after acceptance until the sequence ends; done pulses one cycle on normal
    // completion only. blink_count is sampled with the accepted start and never again.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [TIMER_W-1:0] ON_LAST  = TIMER_W'(ON_TICKS - 1);
    localparam logic [TIMER_W-1:0] OFF_LAST = TIMER_W'(OFF_TICKS - 1);

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic [3:0]         remaining;

    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            remaining <= '0;
            led_out   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        timer <= '0;
                        if (blink_count != 4'd0) begin
                            state     <= ON;
                            remaining <= blink_count;
                            led_out   <= 1'b0;
                            busy      <= 1'b1;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                ON: begin
                    if (abort) begin
                        state     <= IDLE;
                        timer     <= '0;
                        remaining <= '0;
                        led_out   <= 1'b1;
                        busy      <= 1'b0;
                    end else if (timer == ON_LAST) begin
                        state   <= OFF;
                        timer   <= '0;
                        led_out <= 1'b1;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                OFF: begin
                    if (abort) begin
                        state     <= IDLE;
                        timer     <= '0;
                        remaining <= '0;
                        busy      <= 1'b0;
                    end else if (timer == OFF_LAST) begin
                        timer     <= '0;
                        remaining <= remaining - 4'd1;
                        // The last blink's dark phase hands straight over to the done pulse.
                        if (remaining == 4'd1) begin
                            state <= FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state   <= ON;
                            led_out <= 1'b0;
                        end
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                FIN: begin
                    state     <= IDLE;
                    timer     <= '0;
                    remaining <= '0;
                end
                default: begin
                    state   <= IDLE;
                    led_out <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_blinker.sv
// Bench for led_blinker: each scenario queues the expected {led_out, busy, done}
// for every cycle it drives, then pops and compares one vector per clock.
module tb_led_blinker;

    localparam int ON_TICKS  = 4;
    localparam int OFF_TICKS = 3;
    localparam int TIMER_W   = 4;

    localparam logic [2:0] V_IDLE = 3'b100;  // {led_out, busy, done}
    localparam logic [2:0] V_ON   = 3'b010;
    localparam logic [2:0] V_OFF  = 3'b110;
    localparam logic [2:0] V_FIN  = 3'b101;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] blink_count;
    logic       abort;
    logic       busy;
    logic       done;
    logic       led_out;
    logic [1:0] fsm_state;

    logic [2:0] exp_q[$];
    logic [2:0] obs;
    logic [2:0] exp;
    int         vectors;
    int         miscompares;

    led_blinker #(
        .ON_TICKS (ON_TICKS),
        .OFF_TICKS(OFF_TICKS),
        .TIMER_W  (TIMER_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .blink_count(blink_count),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .led_out    (led_out),
        .fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic push_vec(input logic [2:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    task automatic push_blinks(input int n);
        for (int b = 0; b < n; b++) begin
            push_vec(V_ON, ON_TICKS);
            push_vec(V_OFF, OFF_TICKS);
        end
        push_vec(V_FIN, 1);
    endtask

    task automatic sample_cycle();
        @(posedge clk);
        #1;
        obs = {led_out, busy, done};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; blink_count = 4'd0;
        push_vec(V_IDLE, 2);
        repeat (2) begin
            sample_cycle();
            exp = exp_q.pop_front();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL reset: {led,busy,done} got %b expected %b", obs, exp);
            end
        end
        rst_n = 1'b1;
        push_vec(V_IDLE, 10);
        while (exp_q.size() != 0) begin
            sample_cycle();
            exp = exp_q.pop_front();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL idle_after_reset: {led,busy,done} got %b expected %b", obs, exp);
            end
        end
    endtask

    task automatic test_two_blinks();
        blink_count = 4'd2; start = 1'b1;
        push_blinks(2);
        push_vec(V_IDLE, 2);
        sample_cycle();
        start = 1'b0;
        blink_count = 4'($urandom_range(0, 15));
        exp = exp_q.pop_front();
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL two_blinks_first: {led,busy,done} got %b expected %b", obs, exp);
        end
        while (exp_q.size() != 0) begin
            sample_cycle();
            exp = exp_q.pop_front();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL two_blinks: {led,busy,done} got %b expected %b", obs, exp);
            end
        end
    endtask

    task automatic test_start_ignored();
        blink_count = 4'd2; start = 1'b1;
        push_blinks(2);
        push_vec(V_IDLE, 2);
        for (int c = 0; c < 2; c++) begin
            sample_cycle();
            start = 1'b0;
            exp = exp_q.pop_front();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL ignore_pre: {led,busy,done} got %b expected %b", obs, exp);
            end
        end
        start = 1'b1; blink_count = 4'd9;
        sample_cycle();
        start = 1'b0;
        exp = exp_q.pop_front();
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL ignore_pulse: {led,busy,done} got %b expected %b", obs, exp);
        end
        while (exp_q.size() != 0) begin
            sample_cycle();
            exp = exp_q.pop_front();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL ignore_rest: {led,busy,done} got %b expected %b", obs, exp);
            end
        end
    endtask

    task automatic test_held_start();
        blink_count = 4'd1; start = 1'b1;
        push_blinks(1);
        push_vec(V_IDLE, 1);
        push_blinks(1);
        push_vec(V_IDLE, 2);
        for (int c = 0; c < ON_TICKS + OFF_TICKS + 3; c++) begin
            sample_cycle();
            exp = exp_q.pop_front();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL held_start: {led,busy,done} got %b expected %b", obs, exp);
            end
        end
        start = 1'b0;
        while (exp_q.size() != 0) begin
            sample_cycle();
            exp = exp_q.pop_front();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL held_start_rest: {led,busy,done} got %b expected %b", obs, exp);
            end
        end
    endtask

    task automatic test_zero_count();
        blink_count = 4'd0; start = 1'b1;
        push_vec(V_FIN, 1);
        push_vec(V_IDLE, 3);
        sample_cycle();
        start = 1'b0;
        exp = exp_q.pop_front();
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL zero_count_done: {led,busy,done} got %b expected %b", obs, exp);
        end
        while (exp_q.size() != 0) begin
            sample_cycle();
            exp = exp_q.pop_front();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL zero_count_idle: {led,busy,done} got %b expected %b", obs, exp);
            end
        end
    endtask

    task automatic test_abort();
        blink_count = 4'd3; start = 1'b1;
        push_vec(V_ON, 2);
        push_vec(V_IDLE, 3);
        for (int c = 0; c < 5; c++) begin
            sample_cycle();
            start = 1'b0;
            abort = (c == 1);
            exp = exp_q.pop_front();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL abort cyc %0d: {led,busy,done} got %b expected %b", c, obs, exp);
            end
        end
        blink_count = 4'd1; start = 1'b1;
        push_blinks(1);
        push_vec(V_IDLE, 2);
        while (exp_q.size() != 0) begin
            sample_cycle();
            start = 1'b0;
            exp = exp_q.pop_front();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL after_abort: {led,busy,done} got %b expected %b", obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        blink_count = 4'd3; start = 1'b1;
        push_vec(V_ON, ON_TICKS);
        push_vec(V_OFF, OFF_TICKS);
        push_vec(V_ON, ON_TICKS);
        push_vec(V_OFF, 1);
        while (exp_q.size() != 0) begin
            sample_cycle();
            start = 1'b0;
            exp = exp_q.pop_front();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL pre_reset: {led,busy,done} got %b expected %b", obs, exp);
            end
        end
        rst_n = 1'b0;
        push_vec(V_IDLE, 4);
        for (int c = 0; c < 4; c++) begin
            sample_cycle();
            rst_n = 1'b1;
            exp = exp_q.pop_front();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL reset_mid cyc %0d: {led,busy,done} got %b expected %b", c, obs, exp);
            end
        end
    endtask

    task automatic test_start_abort_idle();
        blink_count = 4'd5; start = 1'b1; abort = 1'b1;
        push_vec(V_IDLE, 5);
        for (int c = 0; c < 5; c++) begin
            sample_cycle();
            if (c == 2) begin
                start = 1'b0;
                abort = 1'b0;
            end
            exp = exp_q.pop_front();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL start_abort_idle cyc %0d: {led,busy,done} got %b expected %b", c, obs, exp);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_two_blinks();
        test_start_ignored();
        test_held_start();
        test_zero_count();
        test_abort();
        test_reset_mid();
        test_start_abort_idle();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_queue: got %0d entries expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
